// File: rtl/fetch_decode_32.sv
// Instruction fetch over a req/ack memory handshake and decode into the control fields
// (jump, beq, branch_offset, jump_addr) consumed by pc_control_32.
module fetch_decode_32 #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [31:0] i_pc,
   input  logic        i_fetch_start,
   input  logic        i_alu_zero,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata,
   output logic [31:0] o_instr,
   output logic        o_instr_valid,
   output logic        o_jump,
   output logic        o_beq,
   output logic [31:0] o_branch_offset,
   output logic [25:0] o_jump_addr,
   output logic [4:0]  o_rs,
   output logic [4:0]  o_rt,
   output logic [4:0]  o_rd,
   output logic        o_busy,
   output logic        o_fault
);

   typedef enum logic [1:0] {StIdle, StReq, StDec} state_e;

   state_e            r_state;
   state_e            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_mem_addr;
   logic [31:0]       r_instr;
   logic              r_jump;
   logic              r_is_beq;
   logic              r_fault;

   logic              w_start_ok;
   logic              w_misalign;
   logic              w_timeout;
   logic              w_ack;
   logic [5:0]        w_opcode;

   assign w_start_ok = i_fetch_start && (i_pc[1:0] == 2'b00);
   assign w_misalign = i_fetch_start && (i_pc[1:0] != 2'b00);
   assign w_ack      = (r_state == StReq) && i_mem_ack;
   // Timeout fires on the TIMEOUT-th unacknowledged REQ cycle.
   assign w_timeout  = (r_state == StReq) && !i_mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_opcode   = i_mem_rdata[31:26];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: if (w_start_ok) w_state_nxt = StReq;
         StReq: begin
            if (i_mem_ack)      w_state_nxt = StDec;
            else if (w_timeout) w_state_nxt = StIdle;
         end
         StDec:   w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      o_mem_req     = (r_state == StReq);
      o_busy        = (r_state != StIdle);
      o_instr_valid = (r_state == StDec);
   end

   // Decoded registers load on the ack edge so they are visible during the DEC cycle.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt      <= '0;
         r_mem_addr <= '0;
         r_instr    <= '0;
         r_jump     <= 1'b0;
         r_is_beq   <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_fault <= ((r_state == StIdle) && w_misalign) || w_timeout;
         if ((r_state == StIdle) && w_start_ok) begin
            r_mem_addr <= i_pc;
         end
         if ((r_state == StReq) && !i_mem_ack && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
         if (w_ack) begin
            r_instr  <= i_mem_rdata;
            r_jump   <= (w_opcode == 6'b000010) || (w_opcode == 6'b000011);
            r_is_beq <= (w_opcode == 6'b000100);
         end
      end
   end

   assign o_mem_addr      = r_mem_addr;
   assign o_fault         = r_fault;
   assign o_instr         = r_instr;
   assign o_jump          = r_jump;
   assign o_beq           = r_is_beq && i_alu_zero;
   assign o_branch_offset = {{16{r_instr[15]}}, r_instr[15:0]};
   assign o_jump_addr     = r_instr[25:0];
   assign o_rs            = r_instr[25:21];
   assign o_rt            = r_instr[20:16];
   assign o_rd            = r_instr[15:11];

endmodule

// File: tb/tb_fetch_decode_32.sv
// Scoreboard bench for fetch_decode_32: stimulus pushes expected decodes and faults,
// monitors pop and compare on each instr_valid / fault pulse.
module tb_fetch_decode_32;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pc;
   logic        fetch_start;
   logic        alu_zero;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        jump;
   logic        beq;
   logic [31:0] branch_offset;
   logic [25:0] jump_addr;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic        busy;
   logic        fault;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid  = 0;

   typedef struct {
      logic [31:0] instr;
      logic        jump;
      logic        beq;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] off;
      logic [25:0] jaddr;
   } exp_t;

   exp_t sb_q[$];
   int   fault_q[$];

   fetch_decode_32 #(.TIMEOUT(16), .CNT_W(5)) dut (
      .i_clk           (clk),
      .i_reset_n       (reset_n),
      .i_pc            (pc),
      .i_fetch_start   (fetch_start),
      .i_alu_zero      (alu_zero),
      .o_mem_req       (mem_req),
      .o_mem_addr      (mem_addr),
      .i_mem_ack       (mem_ack),
      .i_mem_rdata     (mem_rdata),
      .o_instr         (instr),
      .o_instr_valid   (instr_valid),
      .o_jump          (jump),
      .o_beq           (beq),
      .o_branch_offset (branch_offset),
      .o_jump_addr     (jump_addr),
      .o_rs            (rs),
      .o_rt            (rt),
      .o_rd            (rd),
      .o_busy          (busy),
      .o_fault         (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] i, input logic j, input logic b,
                               input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                               input logic [31:0] o, input logic [25:0] ja);
      exp_t e;
      e.instr = i; e.jump = j; e.beq = b; e.rs = s; e.rt = t; e.rd = d;
      e.off = o; e.jaddr = ja;
      return e;
   endfunction

   // Decode monitor
   always @(negedge clk) begin
      if (instr_valid) begin
         exp_t e;
         n_valid++;
         if (sb_q.size() == 0) begin
            check("unexpected_instr_valid", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("instr", instr, e.instr);
            check("jump", {31'd0, jump}, {31'd0, e.jump});
            check("beq", {31'd0, beq}, {31'd0, e.beq});
            check("rs", {27'd0, rs}, {27'd0, e.rs});
            check("rt", {27'd0, rt}, {27'd0, e.rt});
            check("rd", {27'd0, rd}, {27'd0, e.rd});
            check("branch_offset", branch_offset, e.off);
            check("jump_addr", {6'd0, jump_addr}, {6'd0, e.jaddr});
         end
      end
   end

   // Fault monitor
   always @(negedge clk) begin
      if (fault) begin
         check("fault_expected", {31'd0, fault_q.size() > 0}, 32'd1);
         if (fault_q.size() > 0) void'(fault_q.pop_front());
      end
   end

   task automatic do_fetch(input logic [31:0] a, input logic [31:0] data, input int waits,
                           input bit poke);
      @(negedge clk);
      pc = a;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      for (int w = 0; w <= waits; w++) begin
         check("mem_req_high", {31'd0, mem_req}, 32'd1);
         check("mem_addr", mem_addr, a);
         if (w == waits) begin
            mem_ack   = 1'b1;
            mem_rdata = data;
         end else if (poke && w == 0) begin
            pc          = a + 32'h100;
            fetch_start = 1'b1;
         end
         @(negedge clk);
         mem_ack     = 1'b0;
         fetch_start = 1'b0;
         mem_rdata   = 32'hDEAD_BEEF;
      end
      check("mem_req_drop", {31'd0, mem_req}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset_n     = 1'b0;
      pc          = '0;
      fetch_start = 1'b0;
      alu_zero    = 1'b0;
      mem_ack     = 1'b0;
      mem_rdata   = '0;
      #12;
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_valid_fault", {30'd0, instr_valid, fault}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: j with same-cycle ack
      sb_q.push_back(mk(32'h0800_0040, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0000_0040,
                        26'h000_0040));
      do_fetch(32'h0000_0010, 32'h0800_0040, 0, 1'b0);

      // 2: beq after 3 wait cycles, alu_zero high
      alu_zero = 1'b1;
      sb_q.push_back(mk(32'h1022_FFFE, 1'b0, 1'b1, 5'd1, 5'd2, 5'd31, 32'hFFFF_FFFE,
                        26'h022_FFFE));
      do_fetch(32'h0000_0020, 32'h1022_FFFE, 3, 1'b0);
      @(negedge clk);
      alu_zero = 1'b0;
      #1 check("beq_follows_alu_zero", {31'd0, beq}, 32'd0);

      // 3: misaligned pc
      fault_q.push_back(1);
      @(negedge clk);
      pc = 32'h0000_0022;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("misalign_mem_req", {31'd0, mem_req}, 32'd0);
      check("misalign_busy", {31'd0, busy}, 32'd0);
      check("misalign_instr_kept", instr, 32'h1022_FFFE);
      check("misalign_offset_kept", branch_offset, 32'hFFFF_FFFE);

      // 4: timeout
      fault_q.push_back(1);
      @(negedge clk);
      pc = 32'h0000_0040;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      n = 0;
      while (mem_req && n < 40) begin
         check("timeout_addr", mem_addr, 32'h0000_0040);
         n++;
         @(negedge clk);
      end
      check("timeout_req_cycles", n, 32'd16);
      check("timeout_busy", {31'd0, busy}, 32'd0);
      check("timeout_instr_kept", instr, 32'h1022_FFFE);

      // 5: async reset mid-REQ, then R-type fetch
      @(negedge clk);
      pc = 32'h0000_0008;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      check("pre_reset_req", {31'd0, mem_req}, 32'd1);
      #3 reset_n = 1'b0;
      #1;
      check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_instr", instr, 32'd0);
      @(negedge clk);
      reset_n  = 1'b1;
      alu_zero = 1'b1;
      sb_q.push_back(mk(32'h0085_3020, 1'b0, 1'b0, 5'd4, 5'd5, 5'd6, 32'h0000_3020,
                        26'h085_3020));
      do_fetch(32'h0000_0004, 32'h0085_3020, 1, 1'b0);

      // 6: fetch_start during REQ is ignored
      alu_zero = 1'b0;
      sb_q.push_back(mk(32'h0C00_0123, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0000_0123,
                        26'h000_0123));
      do_fetch(32'h0000_0100, 32'h0C00_0123, 2, 1'b1);

      repeat (5) @(negedge clk);
      check("no_extra_req", {31'd0, mem_req}, 32'd0);
      check("valid_count", n_valid, 32'd4);
      check("sb_empty", sb_q.size(), 32'd0);
      check("fault_q_empty", fault_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
